// File: rtl/cfu_ram_arb_pkg.sv
// Shared types and constants for the CFU RAM arbiter and its pick logic.
package cfu_ram_arb_pkg;

    // Arbiter ownership states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        ABORT = 2'd2
    } arb_state_e;

    localparam int unsigned DEF_ADR_W = 30;
    localparam int unsigned DEF_DAT_W = 32;

    // Only classic Wishbone cycles are issued on the SoC side
    localparam logic [2:0] WB_CTI_CLASSIC = '0;
    localparam logic [1:0] WB_BTE_LINEAR  = '0;

endpackage

// File: rtl/cfu_ram_arbiter_if.sv
// Bus bundle between the CFU requesters, the arbiter and the SoC cfu_ram port.
// modport slave : the arbiter's view (slave to the requesters, master to cfu_ram)
// modport master: the environment's view (requesters plus the cfu_ram slave)
interface cfu_ram_arbiter_if
    import cfu_ram_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADR_W       = DEF_ADR_W,
    parameter int unsigned DAT_W       = DEF_DAT_W
);
    // Requester side
    logic [NUM_MASTERS-1:0]       m_cyc;
    logic [NUM_MASTERS-1:0]       m_stb;
    logic [NUM_MASTERS-1:0]       m_we;
    logic [NUM_MASTERS*ADR_W-1:0] m_adr;
    logic [NUM_MASTERS*DAT_W-1:0] m_dat_mosi;
    logic [NUM_MASTERS*4-1:0]     m_sel;
    logic [NUM_MASTERS-1:0]       m_ack;
    logic [NUM_MASTERS-1:0]       m_err;
    logic [DAT_W-1:0]             m_dat_miso;

    // SoC cfu_ram side
    logic             cfu_ram_cyc;
    logic             cfu_ram_stb;
    logic             cfu_ram_we;
    logic [ADR_W-1:0] cfu_ram_adr;
    logic [DAT_W-1:0] cfu_ram_dat_mosi;
    logic [3:0]       cfu_ram_sel;
    logic [2:0]       cfu_ram_cti;
    logic [1:0]       cfu_ram_bte;
    logic [DAT_W-1:0] cfu_ram_dat_miso;
    logic             cfu_ram_ack;
    logic             cfu_ram_err;

    modport slave (
        input  m_cyc, m_stb, m_we, m_adr, m_dat_mosi, m_sel,
        output m_ack, m_err, m_dat_miso,
        output cfu_ram_cyc, cfu_ram_stb, cfu_ram_we, cfu_ram_adr,
        output cfu_ram_dat_mosi, cfu_ram_sel, cfu_ram_cti, cfu_ram_bte,
        input  cfu_ram_dat_miso, cfu_ram_ack, cfu_ram_err
    );

    modport master (
        output m_cyc, m_stb, m_we, m_adr, m_dat_mosi, m_sel,
        input  m_ack, m_err, m_dat_miso,
        input  cfu_ram_cyc, cfu_ram_stb, cfu_ram_we, cfu_ram_adr,
        input  cfu_ram_dat_mosi, cfu_ram_sel, cfu_ram_cti, cfu_ram_bte,
        output cfu_ram_dat_miso, cfu_ram_ack, cfu_ram_err
    );

endinterface

// File: rtl/cfu_rr_pick.sv
// Combinational round-robin pick: first set request at or after i_ptr
// (wrapping) wins. Returns a one-hot grant and a valid flag.
module cfu_rr_pick #(
    parameter int unsigned N     = 2,
    parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic             o_valid
);
    logic [N-1:0] w_rot;
    logic [N-1:0] w_rot_1h;

    // Rotate so i_ptr sits at bit 0, isolate the lowest request, rotate back
    always_comb begin
        w_rot    = N'({i_req, i_req} >> i_ptr);
        w_rot_1h = w_rot & (~w_rot + 1'b1);
        o_gnt    = N'(({w_rot_1h, w_rot_1h} << i_ptr) >> N);
        o_valid  = |i_req;
    end

endmodule

// File: rtl/cfu_ram_arbiter.sv
// Round-robin arbiter sharing the single CFU Wishbone classic port among
// NUM_MASTERS requesters. One registered grant at a time; the granted
// master's cycle is forwarded combinationally, ack/err routed back to it only.
// Optional watchdog: define CFU_RAM_ARB_TIMEOUT_EN to abort accesses whose
// slave stalls for TIMEOUT_CYCLES cycles.
module cfu_ram_arbiter
    import cfu_ram_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned ADR_W          = DEF_ADR_W,
    parameter int unsigned DAT_W          = DEF_DAT_W,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    cfu_ram_arbiter_if.slave       bus,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   busy
);
    localparam int unsigned PTR_W = $clog2(NUM_MASTERS);

    arb_state_e             r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [PTR_W-1:0]       r_gidx;
    logic [PTR_W-1:0]       r_ptr;

    logic [NUM_MASTERS-1:0] w_pick_gnt;
    logic                   w_pick_valid;
    logic [PTR_W-1:0]       w_pick_idx;
    logic [PTR_W-1:0]       w_next_ptr;
    logic                   w_timeout;

    cfu_rr_pick #(
        .N     (NUM_MASTERS),
        .PTR_W (PTR_W)
    ) u_pick (
        .i_req   (bus.m_cyc),
        .i_ptr   (r_ptr),
        .o_gnt   (w_pick_gnt),
        .o_valid (w_pick_valid)
    );

    // Encode the one-hot winner into an index for the data muxes
    always_comb begin
        w_pick_idx = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (w_pick_gnt[i]) begin
                w_pick_idx = PTR_W'(i);
            end
        end
    end

    assign w_next_ptr = (r_gidx == PTR_W'(NUM_MASTERS - 1)) ? '0 : r_gidx + 1'b1;

`ifdef CFU_RAM_ARB_TIMEOUT_EN
    localparam int unsigned WDT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDT_W-1:0] r_wdt;

    // Count stalled strobe cycles of the current owner; saturates at the limit
    always_ff @(posedge clk) begin
        if (!reset || r_state != OWNED) begin
            r_wdt <= '0;
        end else if (bus.cfu_ram_ack || bus.cfu_ram_err) begin
            r_wdt <= '0;
        end else if (bus.cfu_ram_stb && r_wdt != WDT_W'(TIMEOUT_CYCLES)) begin
            r_wdt <= r_wdt + 1'b1;
        end
    end

    assign w_timeout = (r_wdt == WDT_W'(TIMEOUT_CYCLES));
`else
    assign w_timeout = 1'b0;
`endif

    // Ownership FSM: arbitrate in IDLE, hold until the owner drops cyc
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_state <= OWNED;
                        r_grant <= w_pick_gnt;
                        r_gidx  <= w_pick_idx;
                    end
                end
                OWNED: begin
                    if (!bus.m_cyc[r_gidx]) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_ptr   <= w_next_ptr;
                    end else if (w_timeout) begin
                        r_state <= ABORT;
                    end
                end
                ABORT: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_ptr   <= w_next_ptr;
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Forward the owner's cycle to the slave and route terminations back
    always_comb begin
        bus.cfu_ram_cyc      = 1'b0;
        bus.cfu_ram_stb      = 1'b0;
        bus.cfu_ram_we       = 1'b0;
        bus.cfu_ram_adr      = '0;
        bus.cfu_ram_dat_mosi = '0;
        bus.cfu_ram_sel      = '0;
        bus.m_ack            = '0;
        bus.m_err            = '0;
        if (r_state == OWNED) begin
            bus.cfu_ram_cyc      = bus.m_cyc[r_gidx];
            bus.cfu_ram_stb      = bus.m_stb[r_gidx];
            bus.cfu_ram_we       = bus.m_we[r_gidx];
            bus.cfu_ram_adr      = bus.m_adr[r_gidx*ADR_W +: ADR_W];
            bus.cfu_ram_dat_mosi = bus.m_dat_mosi[r_gidx*DAT_W +: DAT_W];
            bus.cfu_ram_sel      = bus.m_sel[r_gidx*4 +: 4];
            bus.m_ack[r_gidx]    = bus.cfu_ram_ack;
            bus.m_err[r_gidx]    = bus.cfu_ram_err;
        end else if (r_state == ABORT) begin
            bus.m_err[r_gidx]    = 1'b1;
        end
    end

    assign bus.m_dat_miso  = bus.cfu_ram_dat_miso;
    assign bus.cfu_ram_cti = WB_CTI_CLASSIC;
    assign bus.cfu_ram_bte = WB_BTE_LINEAR;

    assign grant = r_grant;
    assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_cfu_ram_arbiter.sv
// Bench for cfu_ram_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level ownership model built from the arbitration rules.
module tb_cfu_ram_arbiter;

    localparam int N     = 3;
    localparam int ADR_W = 30;
    localparam int DAT_W = 32;
    localparam int TMO   = 4;
`ifdef CFU_RAM_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] grant;
    logic         busy;

    int errors = 0;
    int checks = 0;

    // Reference model: 0 idle, 1 owned, 2 abort
    int mdl_st  = 0;
    int mdl_own = 0;
    int mdl_ptr = 0;
    int mdl_wdt = 0;

    cfu_ram_arbiter_if #(.NUM_MASTERS(N), .ADR_W(ADR_W), .DAT_W(DAT_W)) bus ();

    cfu_ram_arbiter #(
        .NUM_MASTERS    (N),
        .ADR_W          (ADR_W),
        .DAT_W          (DAT_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .grant (grant),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    function automatic void model_step();
        if (!reset) begin
            mdl_st = 0; mdl_own = 0; mdl_ptr = 0; mdl_wdt = 0;
            return;
        end
        case (mdl_st)
            0: begin
                mdl_wdt = 0;
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (mdl_ptr + k) % N;
                    if (bus.m_cyc[i]) begin
                        mdl_own = i; mdl_st = 1;
                        break;
                    end
                end
            end
            1: begin
                if (!bus.m_cyc[mdl_own]) begin
                    mdl_st = 0; mdl_ptr = (mdl_own + 1) % N; mdl_wdt = 0;
                end else if (TMO_EN && mdl_wdt == TMO) begin
                    mdl_st = 2; mdl_wdt = 0;
                end else if (bus.cfu_ram_ack || bus.cfu_ram_err) begin
                    mdl_wdt = 0;
                end else if (bus.m_stb[mdl_own]) begin
                    mdl_wdt = mdl_wdt + 1;
                end
            end
            default: begin
                mdl_st = 0; mdl_ptr = (mdl_own + 1) % N;
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        bus.m_cyc = '0; bus.m_stb = '0; bus.m_we = '0;
        bus.m_adr = '0; bus.m_dat_mosi = '0; bus.m_sel = '0;
        bus.cfu_ram_ack = 1'b0; bus.cfu_ram_err = 1'b0; bus.cfu_ram_dat_miso = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        bus.m_cyc = '1; bus.m_stb = '1; bus.cfu_ram_ack = 1'b1; bus.cfu_ram_err = 1'b1;
        tick(); tick();
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b expected 000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (bus.cfu_ram_cyc !== 1'b0 || bus.cfu_ram_stb !== 1'b0) begin errors++; $display("FAIL reset_strobes: cyc=%b stb=%b expected 0", bus.cfu_ram_cyc, bus.cfu_ram_stb); end
        checks++; if (bus.m_ack !== 3'b000 || bus.m_err !== 3'b000) begin errors++; $display("FAIL reset_term: ack=%b err=%b expected 000", bus.m_ack, bus.m_err); end
        checks++; if (bus.cfu_ram_adr !== '0 || bus.cfu_ram_cti !== 3'd0 || bus.cfu_ram_bte !== 2'd0) begin errors++; $display("FAIL reset_bus: adr=%h cti=%0d bte=%0d expected 0", bus.cfu_ram_adr, bus.cfu_ram_cti, bus.cfu_ram_bte); end
        clear_inputs();
        reset = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        bus.m_cyc[1] = 1'b1; bus.m_stb[1] = 1'b1; bus.m_sel[4 +: 4] = 4'hF;
        bus.m_adr[1*ADR_W +: ADR_W] = 30'h100;
        #1;
        checks++; if (bus.cfu_ram_cyc !== 1'b0) begin errors++; $display("FAIL single_latency: cyc=%b expected 0", bus.cfu_ram_cyc); end
        tick();
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin bus.cfu_ram_ack = 1'b1; bus.cfu_ram_dat_miso = 32'hDEADBEEF; end
            #1;
            checks++; if (bus.cfu_ram_cyc !== 1'b1 || bus.cfu_ram_adr !== 30'h100) begin errors++; $display("FAIL single_fwd c%0d: cyc=%b adr=%h expected 1/100", c, bus.cfu_ram_cyc, bus.cfu_ram_adr); end
            if (c == 3) begin
                checks++; if (bus.m_ack !== 3'b010) begin errors++; $display("FAIL single_ack: got %b expected 010", bus.m_ack); end
                checks++; if (bus.m_dat_miso !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h expected deadbeef", bus.m_dat_miso); end
            end else begin
                checks++; if (bus.m_ack !== 3'b000) begin errors++; $display("FAIL single_noack c%0d: got %b expected 000", c, bus.m_ack); end
            end
            tick();
        end
        clear_inputs();
        tick();
        checks++; if (grant !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL single_release: grant=%b busy=%b expected 000/0", grant, busy); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.m_cyc[0] = 1'b1; bus.m_cyc[1] = 1'b1;
        tick(); tick();
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL simul_first: got %b expected 001", grant); end
        tick();
        bus.m_cyc[0] = 1'b0;
        #1;
        checks++; if (grant !== 3'b001 || bus.cfu_ram_cyc !== 1'b0) begin errors++; $display("FAIL simul_drop: grant=%b cyc=%b expected 001/0", grant, bus.cfu_ram_cyc); end
        tick();
        checks++; if (grant !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL simul_gap: grant=%b busy=%b expected 000/0", grant, busy); end
        tick();
        checks++; if (grant !== 3'b010 || bus.cfu_ram_cyc !== 1'b1) begin errors++; $display("FAIL simul_second: grant=%b cyc=%b expected 010/1", grant, bus.cfu_ram_cyc); end
        clear_inputs();
        tick();
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_seq [4];
        exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b001; exp_seq[3] = 3'b010;
        do_reset();
        bus.m_cyc[0] = 1'b1; bus.m_cyc[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int waited;
            waited = 0;
            while (grant === 3'b000 && waited < 5) begin
                tick();
                waited++;
            end
            checks++; if (grant !== exp_seq[k]) begin errors++; $display("FAIL fair_grant%0d: got %b expected %b (waited %0d)", k, grant, exp_seq[k], waited); end
            for (int i = 0; i < N; i++) begin
                if (grant[i]) begin
                    bus.m_cyc[i] = 1'b0;
                    tick();
                    bus.m_cyc[i] = 1'b1;
                end
            end
        end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_slave_err();
        do_reset();
        bus.m_cyc[0] = 1'b1; bus.m_stb[0] = 1'b1;
        tick();
        bus.cfu_ram_err = 1'b1;
        #1;
        checks++; if (bus.m_err !== 3'b001 || bus.m_ack !== 3'b000) begin errors++; $display("FAIL err_route: err=%b ack=%b expected 001/000", bus.m_err, bus.m_ack); end
        tick();
        bus.cfu_ram_err = 1'b0;
        #1;
        checks++; if (bus.m_err !== 3'b000 || grant !== 3'b001) begin errors++; $display("FAIL err_hold: err=%b grant=%b expected 000/001", bus.m_err, grant); end
        bus.m_cyc[0] = 1'b0; bus.m_stb[0] = 1'b0;
        tick();
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL err_release: got %b expected 000", grant); end
    endtask

    task automatic test_watchdog();
        do_reset();
        bus.m_cyc[2] = 1'b1; bus.m_stb[2] = 1'b1;
        tick();
`ifdef CFU_RAM_ARB_TIMEOUT_EN
        for (int c = 1; c <= TMO + 1; c++) begin
            #1;
            checks++; if (bus.cfu_ram_cyc !== 1'b1 || bus.m_err !== 3'b000) begin errors++; $display("FAIL wdt_stall c%0d: cyc=%b err=%b expected 1/000", c, bus.cfu_ram_cyc, bus.m_err); end
            tick();
        end
        bus.cfu_ram_ack = 1'b1;
        #1;
        checks++; if (bus.cfu_ram_cyc !== 1'b0 || bus.cfu_ram_stb !== 1'b0) begin errors++; $display("FAIL wdt_abort_bus: cyc=%b stb=%b expected 0", bus.cfu_ram_cyc, bus.cfu_ram_stb); end
        checks++; if (bus.m_err !== 3'b100 || bus.m_ack !== 3'b000) begin errors++; $display("FAIL wdt_abort_term: err=%b ack=%b expected 100/000", bus.m_err, bus.m_ack); end
        checks++; if (grant !== 3'b100 || busy !== 1'b1) begin errors++; $display("FAIL wdt_abort_grant: grant=%b busy=%b expected 100/1", grant, busy); end
        tick();
        clear_inputs();
        #1;
        checks++; if (grant !== 3'b000 || busy !== 1'b0 || bus.m_err !== 3'b000) begin errors++; $display("FAIL wdt_idle: grant=%b busy=%b err=%b expected 000/0/000", grant, busy, bus.m_err); end
        tick();
`else
        for (int c = 1; c <= 120; c++) begin
            #1;
            checks++; if (bus.cfu_ram_cyc !== 1'b1 || bus.m_err !== 3'b000) begin errors++; $display("FAIL hang_hold c%0d: cyc=%b err=%b expected 1/000", c, bus.cfu_ram_cyc, bus.m_err); end
            tick();
        end
        checks++; if (grant !== 3'b100) begin errors++; $display("FAIL hang_grant: got %b expected 100", grant); end
        clear_inputs();
        tick(); tick();
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.m_cyc[1] = 1'b1;
        tick();
        bus.m_cyc[1] = 1'b0;
        tick();
        bus.m_cyc[1] = 1'b1; bus.m_stb[1] = 1'b1;
        bus.m_adr[1*ADR_W +: ADR_W] = 30'h2AB; bus.m_sel[4 +: 4] = 4'hA;
        tick();
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL rstmid_owned: got %b expected 010", grant); end
        reset = 1'b0;
        tick();
        bus.cfu_ram_ack = 1'b1;
        #1;
        checks++; if (bus.cfu_ram_cyc !== 1'b0 || bus.cfu_ram_stb !== 1'b0 || bus.cfu_ram_adr !== '0 || bus.cfu_ram_sel !== 4'h0) begin errors++; $display("FAIL rstmid_bus: cyc=%b stb=%b adr=%h sel=%h expected 0", bus.cfu_ram_cyc, bus.cfu_ram_stb, bus.cfu_ram_adr, bus.cfu_ram_sel); end
        checks++; if (grant !== 3'b000 || busy !== 1'b0 || bus.m_ack !== 3'b000) begin errors++; $display("FAIL rstmid_state: grant=%b busy=%b ack=%b expected 000/0/000", grant, busy, bus.m_ack); end
        reset = 1'b1;
        clear_inputs();
        bus.m_cyc[0] = 1'b1; bus.m_cyc[2] = 1'b1;
        tick();
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL rstmid_ptr: got %b expected 001", grant); end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_random();
        logic [N-1:0]     e_grant, e_ack, e_err;
        logic             e_cyc, e_stb, e_we, e_busy;
        logic [ADR_W-1:0] e_adr;
        logic [DAT_W-1:0] e_dat;
        logic [3:0]       e_sel;
        do_reset();
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < N; i++) begin
                if (bus.m_cyc[i]) begin
                    if ($urandom_range(0, 3) == 0) bus.m_cyc[i] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    bus.m_cyc[i] = 1'b1;
                end
                bus.m_stb[i] = ($urandom_range(0, 3) != 0);
                bus.m_we[i]  = $urandom_range(0, 1) == 1;
                bus.m_adr[i*ADR_W +: ADR_W]      = ADR_W'($urandom);
                bus.m_dat_mosi[i*DAT_W +: DAT_W] = $urandom;
                bus.m_sel[i*4 +: 4]              = 4'($urandom);
            end
            bus.cfu_ram_ack      = ($urandom_range(0, 2) == 0);
            bus.cfu_ram_err      = ($urandom_range(0, 9) == 0);
            bus.cfu_ram_dat_miso = $urandom;
            reset = ($urandom_range(0, 199) != 0);
            #1;
            e_grant = '0; e_ack = '0; e_err = '0;
            e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
            e_adr = '0; e_dat = '0; e_sel = '0;
            e_busy = (mdl_st != 0);
            if (mdl_st != 0) e_grant[mdl_own] = 1'b1;
            if (mdl_st == 1) begin
                e_cyc = bus.m_cyc[mdl_own];
                e_stb = bus.m_stb[mdl_own];
                e_we  = bus.m_we[mdl_own];
                e_adr = bus.m_adr[mdl_own*ADR_W +: ADR_W];
                e_dat = bus.m_dat_mosi[mdl_own*DAT_W +: DAT_W];
                e_sel = bus.m_sel[mdl_own*4 +: 4];
                e_ack[mdl_own] = bus.cfu_ram_ack;
                e_err[mdl_own] = bus.cfu_ram_err;
            end else if (mdl_st == 2) begin
                e_err[mdl_own] = 1'b1;
            end
            checks++; if (grant !== e_grant) begin errors++; $display("FAIL rnd_grant t%0d: got %b expected %b", t, grant, e_grant); end
            checks++; if (busy !== e_busy) begin errors++; $display("FAIL rnd_busy t%0d: got %b expected %b", t, busy, e_busy); end
            checks++; if ({bus.cfu_ram_cyc, bus.cfu_ram_stb, bus.cfu_ram_we} !== {e_cyc, e_stb, e_we}) begin errors++; $display("FAIL rnd_strobes t%0d: got %b%b%b expected %b%b%b", t, bus.cfu_ram_cyc, bus.cfu_ram_stb, bus.cfu_ram_we, e_cyc, e_stb, e_we); end
            checks++; if (bus.cfu_ram_adr !== e_adr) begin errors++; $display("FAIL rnd_adr t%0d: got %h expected %h", t, bus.cfu_ram_adr, e_adr); end
            checks++; if (bus.cfu_ram_dat_mosi !== e_dat) begin errors++; $display("FAIL rnd_mosi t%0d: got %h expected %h", t, bus.cfu_ram_dat_mosi, e_dat); end
            checks++; if (bus.cfu_ram_sel !== e_sel) begin errors++; $display("FAIL rnd_sel t%0d: got %h expected %h", t, bus.cfu_ram_sel, e_sel); end
            checks++; if (bus.m_ack !== e_ack) begin errors++; $display("FAIL rnd_ack t%0d: got %b expected %b", t, bus.m_ack, e_ack); end
            checks++; if (bus.m_err !== e_err) begin errors++; $display("FAIL rnd_err t%0d: got %b expected %b", t, bus.m_err, e_err); end
            checks++; if (bus.m_dat_miso !== bus.cfu_ram_dat_miso) begin errors++; $display("FAIL rnd_miso t%0d: got %h expected %h", t, bus.m_dat_miso, bus.cfu_ram_dat_miso); end
            tick();
        end
        reset = 1'b1;
        clear_inputs();
        tick(); tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_slave_err();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL global_timeout: simulation did not complete within time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
